button_debounce_mc: RTL

- Multi-channel, parametrised successor to the single-channel push-button debouncer used for board reset and button inputs on the FPGA top.
- Each channel has:
  - an input synchroniser,
  - a four-state debounce FSM with a programmable stable-time,
  - rising and falling edge pulses,
  - optional long-press detection,
  - a sticky release latch that replaces the hand-written cpu_rstn flop in the top level.
- Sits between board/VIO button inputs and the reset/control logic, on the 50 MHz debug clock domain.

---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/button_debounce_mc_if.sv | 37 +++
 rtl/button_debounce_ch.sv | 154 +++++++++++++++
 rtl/button_debounce_mc.sv | 59 +++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel push-button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO,
    CHK_HI,
    ST_HI,
    CHK_LO
  } deb_state_e;

  // Counter must hold the larger of the two qualification periods without wrapping.
  function automatic int unsigned cnt_w(input int unsigned deb_cyc, input int unsigned hold_cyc);
    int unsigned m;
    m = (deb_cyc > hold_cyc) ? deb_cyc : hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce_mc_if.sv
// Bundle of per-channel button inputs and debounced outputs.
interface button_debounce_mc_if #(
    parameter int unsigned NUM_CH = 4
);

    logic [NUM_CH-1:0] button_i;
    logic [NUM_CH-1:0] en_i;
    logic [NUM_CH-1:0] clr_i;
    logic [NUM_CH-1:0] level_o;
    logic [NUM_CH-1:0] rflag_o;
    logic [NUM_CH-1:0] fflag_o;
    logic [NUM_CH-1:0] hold_o;
    logic [NUM_CH-1:0] latch_o;

    modport master (
        output button_i,
        output en_i,
        output clr_i,
        input  level_o,
        input  rflag_o,
        input  fflag_o,
        input  hold_o,
        input  latch_o
    );

    modport slave (
        input  button_i,
        input  en_i,
        input  clr_i,
        output level_o,
        output rflag_o,
        output fflag_o,
        output hold_o,
        output latch_o
    );

endinterface

// File: rtl/button_debounce_ch.sv
// One debounce channel: synchroniser, four-state qualification FSM, edge/hold pulses
// and a sticky release latch.
module button_debounce_ch
    import button_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned HOLD_CYC     = 0,
    parameter logic        INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_button,
    input  logic i_en,
    input  logic i_clr,
    output logic o_level,
    output logic o_rflag,
    output logic o_fflag,
    output logic o_hold,
    output logic o_latch
);

    localparam int unsigned CNT_W = cnt_w(DEBOUNCE_CYC, HOLD_CYC);
    localparam bit HOLD_EN = (HOLD_CYC != 0);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(HOLD_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(HOLD_CYC);
    localparam deb_state_e INIT_STATE = INIT_LEVEL ? ST_HI : ST_LO;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    deb_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_level, w_level_d;
    logic             r_rflag, w_rflag_d;
    logic             r_fflag, w_fflag_d;
    logic             r_hold, w_hold_d;
    logic             r_latch, w_latch_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_button};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        w_rflag_d = 1'b0;
        w_fflag_d = 1'b0;
        w_hold_d  = 1'b0;

        if (!i_en) begin
            // Forced idle: no edge pulses even if the level drops.
            w_state_d = ST_LO;
            w_cnt_d   = '0;
            w_level_d = 1'b0;
        end else begin
            unique case (r_state)
                ST_LO: begin
                    if (w_s) begin
                        w_state_d = CHK_HI;
                        w_cnt_d   = '0;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        w_state_d = ST_LO;
                        w_cnt_d   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_d = ST_HI;
                        w_level_d = 1'b1;
                        w_rflag_d = 1'b1;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!w_s) begin
                        w_state_d = CHK_LO;
                        w_cnt_d   = '0;
                    end else if (HOLD_EN && (r_cnt == HOLD_LAST)) begin
                        // Park above the compare value so the pulse fires once per press.
                        w_hold_d = 1'b1;
                        w_cnt_d  = HOLD_SAT;
                    end else if (HOLD_EN && (r_cnt < HOLD_SAT)) begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                CHK_LO: begin
                    if (w_s) begin
                        w_state_d = ST_HI;
                        w_cnt_d   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_d = ST_LO;
                        w_level_d = 1'b0;
                        w_fflag_d = 1'b1;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = ST_LO;
                    w_cnt_d   = '0;
                    w_level_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_latch_d = r_latch;
        if (i_clr) begin
            w_latch_d = 1'b0;
        end else if (r_rflag) begin
            w_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= INIT_STATE;
            r_cnt   <= '0;
            r_level <= INIT_LEVEL;
            r_rflag <= 1'b0;
            r_fflag <= 1'b0;
            r_hold  <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
            r_rflag <= w_rflag_d;
            r_fflag <= w_fflag_d;
            r_hold  <= w_hold_d;
            r_latch <= w_latch_d;
        end
    end

    assign o_level = r_level;
    assign o_rflag = r_rflag;
    assign o_fflag = r_fflag;
    assign o_hold  = r_hold;
    assign o_latch = r_latch;

endmodule

// File: rtl/button_debounce_mc.sv
// Multi-channel push-button debouncer; one independent debounce channel per button
// input, all registered outputs on the single clock domain.
module button_debounce_mc
    import button_debounce_pkg::*;
#(
    parameter int unsigned       NUM_CH       = 4,
    parameter int unsigned       SYNC_STAGES  = 2,
    parameter int unsigned       DEBOUNCE_CYC = 1000000,
    parameter int unsigned       HOLD_CYC     = 0,
    parameter logic [NUM_CH-1:0] INIT_LEVEL   = '0
) (
    input logic                 clk,
    input logic                 rstn,
    button_debounce_mc_if.slave bus
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $fatal(1, "button_debounce_mc: NUM_CH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "button_debounce_mc: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_deb
        $fatal(1, "button_debounce_mc: DEBOUNCE_CYC must be at least 1");
    end

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rflag;
    logic [NUM_CH-1:0] w_fflag;
    logic [NUM_CH-1:0] w_hold;
    logic [NUM_CH-1:0] w_latch;

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .HOLD_CYC    (HOLD_CYC),
            .INIT_LEVEL  (INIT_LEVEL[i])
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .i_button(bus.button_i[i]),
            .i_en    (bus.en_i[i]),
            .i_clr   (bus.clr_i[i]),
            .o_level (w_level[i]),
            .o_rflag (w_rflag[i]),
            .o_fflag (w_fflag[i]),
            .o_hold  (w_hold[i]),
            .o_latch (w_latch[i])
        );
    end

    assign bus.level_o = w_level;
    assign bus.rflag_o = w_rflag;
    assign bus.fflag_o = w_fflag;
    assign bus.hold_o  = w_hold;
    assign bus.latch_o = w_latch;

endmodule
